// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input/commutator stages: default sizes,
// derived widths and the IDLE/FILL/PAIR state encoding.
package fft_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int N_DEF      = 8;

    // Width of a pair/twiddle index for frame length n (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n / 2);
    endfunction

    // Width of the in-frame sample counter for frame length n.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int IDX_W_DEF = idx_w(N_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PAIR = 2'd2
    } fft_state_t;

endpackage

// File: rtl/fft_pair_commutator_if.sv
// Serial sample stream in, butterfly pair stream out.
interface fft_pair_commutator_if
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF
);
    logic              in_valid;
    logic              in_sof;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [IDX_W-1:0]  out_index;
    logic              out_sof;
    logic              out_eof;
    logic              frame_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  out_valid, out_a, out_b, out_index, out_sof, out_eof, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output out_valid, out_a, out_b, out_index, out_sof, out_eof, frame_err
    );
endinterface

// File: rtl/fft_pair_buffer.sv
// First-half frame store: one synchronous write port, one combinational read.
module fft_pair_buffer #(
    parameter int DATA_W = 8,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fft_pair_commutator.sv
// Buffers the first half of each N-sample frame, then emits (x[k], x[k+N/2], k)
// one cycle after each second-half sample is accepted.
//
// state | meaning
// IDLE  | waiting for in_sof; samples without it are dropped
// FILL  | storing x[0..N/2-1] into the buffer
// PAIR  | pairing each incoming x[k+N/2] with buffered x[k]
module fft_pair_commutator
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N      = N_DEF
) (
    input logic clk,
    input logic rst_n,
    fft_pair_commutator_if.slave bus
);
    localparam int IDX_W = idx_w(N);
    localparam int CNT_W = cnt_w(N);
    localparam int HALF  = N / 2;

    fft_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  k, wr_addr;
    logic              wr_en, emit, abort;
    logic [DATA_W-1:0] rd_data;

    assign k = IDX_W'(cnt - CNT_W'(HALF));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        wr_addr   = IDX_W'(cnt);
        emit      = 1'b0;
        abort     = 1'b0;
        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // Any in_sof restarts the frame; only a mid-frame one is an error.
                abort     = (state != ST_IDLE);
                wr_en     = 1'b1;
                wr_addr   = '0;
                cnt_nxt   = CNT_W'(1);
                state_nxt = (HALF == 1) ? ST_PAIR : ST_FILL;
            end else begin
                unique case (state)
                    ST_IDLE: ;
                    ST_FILL: begin
                        wr_en   = 1'b1;
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(HALF - 1)) begin
                            state_nxt = ST_PAIR;
                        end
                    end
                    ST_PAIR: begin
                        emit = 1'b1;
                        if (cnt == CNT_W'(N - 1)) begin
                            cnt_nxt   = '0;
                            state_nxt = ST_IDLE;
                        end else begin
                            cnt_nxt = cnt + CNT_W'(1);
                        end
                    end
                    default: state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_a     <= '0;
            bus.out_b     <= '0;
            bus.out_index <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.out_valid <= emit;
            bus.out_sof   <= emit && (k == '0);
            bus.out_eof   <= emit && (k == IDX_W'(HALF - 1));
            bus.frame_err <= abort;
            if (emit) begin
                bus.out_a     <= rd_data;
                bus.out_b     <= bus.in_data;
                bus.out_index <= k;
            end
        end
    end

    fft_pair_buffer #(
        .DATA_W (DATA_W),
        .AW     (IDX_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (bus.in_data),
        .rd_addr (k),
        .rd_data (rd_data)
    );
endmodule
